controle_calc: RTL and testbench

CONTROLE_CALC -- requirements
Module: controle_calc

---
 rtl/controle_calc.sv | 244 ++++++++++++++++++++++++
 tb/tb_controle_calc.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_calc.sv
// -----------------------------------------------------------------------------
// controle_calc
//
// Sequencing controller for a small register bank plus ALU datapath. It runs
// one calculation per accepted start request:
//   1. write operand A into bank slot FonteA      (ESC_A)
//   2. write operand B into bank slot FonteB      (ESC_B)
//   3. read both slots through the ALU            (LEITURA)
//   4. write the registered ALU result to slot
//      Acumulador                                 (ESC_ACC)
//   5. signal completion                          (FIM)
//
// Optional feature, macro CONTROLE_ACUMULA_EN:
//   When defined, a start request with Acumula=1 skips ESC_A. During LEITURA
//   the first ALU operand is then read from the accumulator slot, so results
//   can be chained. When undefined, Acumula is ignored.
//
// Parameters
//   LARGURA       width of operand, write-data and ALU-result buses
//
// Ports
//   Clock         rising-edge clock
//   ResetN        asynchronous active-low reset
//   Inicio        start request, only sampled while idle
//   Operacao      operation code, captured with Inicio (values > 3'b100 invalid)
//   Acumula       chain-mode request, captured with Inicio
//   OperandoA/B   operands, captured with Inicio
//   ResultadoUla  combinational ALU result for the current Fonte1/Fonte2/OpUla
//   IdReg         bank write index (00 FonteA, 01 FonteB, 10 Acumulador)
//   Escrita       bank write enable
//   DadoEscrita   bank write data
//   Fonte1/2      bank read selects feeding the ALU
//   OpUla         ALU operation select
//   Ocupado       high whenever a sequence is in progress
//   Pronto        one-cycle completion pulse
//   Erro          invalid-operation flag, qualified by Pronto
// -----------------------------------------------------------------------------
module controle_calc #(
    parameter int unsigned LARGURA = 32
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Inicio,
    input  logic [2:0]         Operacao,
    input  logic               Acumula,
    input  logic [LARGURA-1:0] OperandoA,
    input  logic [LARGURA-1:0] OperandoB,
    input  logic [LARGURA-1:0] ResultadoUla,
    output logic [1:0]         IdReg,
    output logic               Escrita,
    output logic [LARGURA-1:0] DadoEscrita,
    output logic [1:0]         Fonte1,
    output logic [1:0]         Fonte2,
    output logic [2:0]         OpUla,
    output logic               Ocupado,
    output logic               Pronto,
    output logic               Erro
);

    // Bank slot indices
    localparam logic [1:0] IdFonteA     = 2'b00;
    localparam logic [1:0] IdFonteB     = 2'b01;
    localparam logic [1:0] IdAcumulador = 2'b10;

    // Highest legal operation code
    localparam logic [2:0] OpMaxValida  = 3'b100;

    typedef enum logic [2:0] {
        StOcioso,
        StEscA,
        StEscB,
        StLeitura,
        StEscAcc,
        StFim
    } estado_e;

    estado_e              estado_q, estado_d;
    logic [2:0]           operacao_q, operacao_d;
    logic [LARGURA-1:0]   operando_a_q, operando_a_d;
    logic [LARGURA-1:0]   operando_b_q, operando_b_d;
    logic [LARGURA-1:0]   resultado_q, resultado_d;

    logic                 captura;
    logic                 op_invalida;
    logic                 pula_esc_a;
    logic [1:0]           fonte1_leitura;

    // Start is only honoured while idle; everything latched stays frozen after.
    assign captura     = (estado_q == StOcioso) && Inicio;
    assign op_invalida = operacao_q > OpMaxValida;

`ifdef CONTROLE_ACUMULA_EN
    logic acumula_q, acumula_d;

    always_comb begin
        acumula_d = acumula_q;
        if (captura) begin
            acumula_d = Acumula;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            acumula_q <= 1'b0;
        end else begin
            acumula_q <= acumula_d;
        end
    end

    // The transition out of idle happens on the capture edge, so it looks at
    // the input directly; it is the same value that acumula_q takes.
    assign pula_esc_a     = Acumula;
    // Chained mode takes operand A from the previous result.
    assign fonte1_leitura = acumula_q ? IdAcumulador : IdFonteA;
`else
    logic unused_acumula;

    assign unused_acumula = Acumula;
    assign pula_esc_a     = 1'b0;
    assign fonte1_leitura = IdFonteA;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            estado_q <= StOcioso;
        end else begin
            estado_q <= estado_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StOcioso: begin
                if (Inicio) begin
                    estado_d = pula_esc_a ? StEscB : StEscA;
                end
            end
            StEscA:    estado_d = StEscB;
            StEscB:    estado_d = StLeitura;
            StLeitura: estado_d = StEscAcc;
            StEscAcc:  estado_d = StFim;
            // Inicio seen in FIM is deliberately dropped; a new start needs
            // an idle cycle.
            StFim:     estado_d = StOcioso;
            default:   estado_d = StOcioso;
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand, operation and result registers
    // -------------------------------------------------------------------------
    always_comb begin
        operacao_d   = operacao_q;
        operando_a_d = operando_a_q;
        operando_b_d = operando_b_q;
        resultado_d  = resultado_q;

        if (captura) begin
            operacao_d   = Operacao;
            operando_a_d = OperandoA;
            operando_b_d = OperandoB;
        end

        // ALU inputs are stable during LEITURA; sample at the end of it.
        if (estado_q == StLeitura) begin
            resultado_d = ResultadoUla;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            operacao_q   <= '0;
            operando_a_q <= '0;
            operando_b_q <= '0;
            resultado_q  <= '0;
        end else begin
            operacao_q   <= operacao_d;
            operando_a_q <= operando_a_d;
            operando_b_q <= operando_b_d;
            resultado_q  <= resultado_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    //
    // Purely decoded from state so that an asynchronous reset returns every
    // output to its idle value without waiting for a clock edge.
    // -------------------------------------------------------------------------
    always_comb begin
        IdReg       = IdFonteA;
        Escrita     = 1'b0;
        DadoEscrita = '0;
        Fonte1      = 2'b00;
        Fonte2      = 2'b00;
        OpUla       = 3'b000;
        Ocupado     = (estado_q != StOcioso);
        Pronto      = 1'b0;
        Erro        = 1'b0;

        unique case (estado_q)
            StOcioso: begin
            end
            StEscA: begin
                IdReg       = IdFonteA;
                Escrita     = ~op_invalida;
                DadoEscrita = operando_a_q;
            end
            StEscB: begin
                IdReg       = IdFonteB;
                Escrita     = ~op_invalida;
                DadoEscrita = operando_b_q;
            end
            StLeitura: begin
                Fonte1 = fonte1_leitura;
                Fonte2 = IdFonteB;
                OpUla  = operacao_q;
            end
            StEscAcc: begin
                // Read selects keep their LEITURA values while writing back.
                Fonte1      = fonte1_leitura;
                Fonte2      = IdFonteB;
                OpUla       = operacao_q;
                IdReg       = IdAcumulador;
                Escrita     = ~op_invalida;
                DadoEscrita = resultado_q;
            end
            StFim: begin
                Pronto = 1'b1;
                Erro   = op_invalida;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_controle_calc.sv
module tb_controle_calc;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inicio;
    logic [2:0]    operacao;
    logic          acumula;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  resultado_ula;
    logic [1:0]    id_reg;
    logic          escrita;
    logic [W-1:0]  dado_escrita;
    logic [1:0]    fonte1;
    logic [1:0]    fonte2;
    logic [2:0]    op_ula;
    logic          ocupado;
    logic          pronto;
    logic          erro;

    controle_calc #(.LARGURA(W)) dut (
        .Clock       (clk),
        .ResetN      (rst_n),
        .Inicio      (inicio),
        .Operacao    (operacao),
        .Acumula     (acumula),
        .OperandoA   (op_a),
        .OperandoB   (op_b),
        .ResultadoUla(resultado_ula),
        .IdReg       (id_reg),
        .Escrita     (escrita),
        .DadoEscrita (dado_escrita),
        .Fonte1      (fonte1),
        .Fonte2      (fonte2),
        .OpUla       (op_ula),
        .Ocupado     (ocupado),
        .Pronto      (pronto),
        .Erro        (erro)
    );

    always #5 clk = ~clk;

    // Register bank and ALU model
    logic [W-1:0] bank [0:3];
    logic [W-1:0] rd1, rd2;

    always @(posedge clk) begin
        if (escrita) bank[id_reg] <= dado_escrita;
    end

    always_comb begin
        rd1 = bank[fonte1];
        rd2 = bank[fonte2];
        case (op_ula)
            3'b000:  resultado_ula = rd1 + rd2;
            3'b001:  resultado_ula = rd1 - rd2;
            3'b010:  resultado_ula = rd1 & rd2;
            3'b011:  resultado_ula = rd1 | rd2;
            3'b100:  resultado_ula = rd1 ^ rd2;
            default: resultado_ula = '0;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_escrita"}, {31'd0, escrita}, 0);
        chk({tag, "_idreg"},   {30'd0, id_reg}, 0);
        chk({tag, "_fonte1"},  {30'd0, fonte1}, 0);
        chk({tag, "_fonte2"},  {30'd0, fonte2}, 0);
        chk({tag, "_opula"},   {29'd0, op_ula}, 0);
        chk({tag, "_dado"},    dado_escrita, 0);
        chk({tag, "_ocupado"}, {31'd0, ocupado}, 0);
        chk({tag, "_pronto"},  {31'd0, pronto}, 0);
        chk({tag, "_erro"},    {31'd0, erro}, 0);
    endtask

    // Observations from the last run_op
    logic [1:0]   wr_id  [8];
    logic [W-1:0] wr_dat [8];
    int           n_wr;
    int           lat;
    int           n_pronto;
    logic         erro_s;
    logic [1:0]   fonte1_acc;
    logic         bad_id;
    logic         bad_busy;

    // Issue one start and follow it until Pronto (bounded), then watch three
    // idle cycles. lat counts falling edges after Inicio was raised.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acum, input logic pulse_busy, input logic hold_fim);
        n_wr = 0; lat = 0; n_pronto = 0; erro_s = 1'b0; fonte1_acc = 2'b11;
        bad_id = 1'b0; bad_busy = 1'b0;
        @(negedge clk);
        inicio = 1'b1; operacao = op; op_a = a; op_b = b; acumula = acum;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            inicio = pulse_busy && (cyc == 2);
            if (pulse_busy && cyc == 2) begin
                op_a = ~a; op_b = ~b; operacao = 3'b001; acumula = ~acum;
            end
            if (id_reg == 2'b11) bad_id = 1'b1;
            if (!ocupado) bad_busy = 1'b1;
            if (escrita && n_wr < 8) begin
                wr_id[n_wr]  = id_reg;
                wr_dat[n_wr] = dado_escrita;
                n_wr++;
                if (id_reg == 2'b10) fonte1_acc = fonte1;
            end
            if (pronto) begin
                n_pronto++;
                lat    = cyc;
                erro_s = erro;
                inicio = hold_fim;
                break;
            end
        end
        @(negedge clk);
        inicio = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (pronto) n_pronto++;
            if (ocupado) bad_busy = 1'b1;
            if (escrita) n_wr++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        logic [W-1:0] exp_acc;
        logic         exp_erro;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic chk_writes3(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] r);
        chk({tag, "_nwr"}, n_wr, 3);
        if (n_wr == 3) begin
            chk({tag, "_w0id"}, {30'd0, wr_id[0]}, 0);
            chk({tag, "_w0d"},  wr_dat[0], a);
            chk({tag, "_w1id"}, {30'd0, wr_id[1]}, 1);
            chk({tag, "_w1d"},  wr_dat[1], b);
            chk({tag, "_w2id"}, {30'd0, wr_id[2]}, 2);
            chk({tag, "_w2d"},  wr_dat[2], r);
        end
    endtask

    initial begin
        logic [W-1:0] acc_before;
        int           pr_cnt;
        int           wr_cnt;

        vecs[0] = '{3'b000, 32'd5,         32'd3,         32'd5,         32'd3,         32'd8,         1'b0};
        vecs[1] = '{3'b001, 32'd10,        32'd3,         32'd10,        32'd3,         32'd7,         1'b0};
        vecs[2] = '{3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
        vecs[3] = '{3'b011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0};
        vecs[4] = '{3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        vecs[5] = '{3'b111, 32'd1,         32'd2,         32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b1};
        vecs[6] = '{3'b101, 32'd3,         32'd4,         32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b1};
        vecs[7] = '{3'b001, 32'd3,         32'd5,         32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        vecs[8] = '{3'b110, 32'd77,        32'd88,        32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1};

        rst_n = 1'b0; inicio = 1'b0; operacao = 3'b000; acumula = 1'b0;
        op_a = '0; op_b = '0;
        #1;
        chk_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("idle");

        // Table-driven sequences
        for (int i = 0; i < NV; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 1'b0);
            chk({t, "_lat"},    lat, 5);
            chk({t, "_pronto"}, n_pronto, 1);
            chk({t, "_erro"},   {31'd0, erro_s}, {31'd0, vecs[i].exp_erro});
            chk({t, "_busy"},   {31'd0, bad_busy}, 0);
            chk({t, "_id11"},   {31'd0, bad_id}, 0);
            if (vecs[i].exp_erro) begin
                chk({t, "_nwr"}, n_wr, 0);
            end else begin
                chk_writes3(t, vecs[i].a, vecs[i].b, vecs[i].exp_acc);
                chk({t, "_f1"}, {30'd0, fonte1_acc}, 0);
            end
            chk({t, "_bankA"}, bank[0], vecs[i].exp_a);
            chk({t, "_bankB"}, bank[1], vecs[i].exp_b);
            chk({t, "_bankC"}, bank[2], vecs[i].exp_acc);
        end

        // Inicio pulsed in ESC_B with changed inputs, and held high in FIM
        run_op(3'b000, 32'd20, 32'd22, 1'b0, 1'b1, 1'b1);
        chk("busy_lat",    lat, 5);
        chk("busy_pronto", n_pronto, 1);
        chk("busy_idle",   {31'd0, bad_busy}, 0);
        chk_writes3("busy", 32'd20, 32'd22, 32'd42);

        // Reset in the middle of LEITURA
        acc_before = bank[2];
        @(negedge clk);
        inicio = 1'b1; operacao = 3'b001; op_a = 32'd9; op_b = 32'd7; acumula = 1'b0;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_fonte2", {30'd0, fonte2}, 1);
        chk("mid_opula",  {29'd0, op_ula}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rstmid");
        pr_cnt = 0; wr_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (pronto) pr_cnt++;
            if (escrita) wr_cnt++;
        end
        chk("rstmid_pronto", pr_cnt, 0);
        chk("rstmid_writes", wr_cnt, 0);
        chk("rstmid_acc",    bank[2], acc_before);
        chk("rstmid_busy",   {31'd0, ocupado}, 0);
        run_op(3'b001, 32'd9, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("post_lat", lat, 5);
        chk("post_erro", {31'd0, erro_s}, 0);
        chk_writes3("post", 32'd9, 32'd7, 32'd2);

        // Chained mode: accumulator = 8 first, then Acumula=1 with B=2
        run_op(3'b000, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("pre_acc", bank[2], 32'd8);
        run_op(3'b000, 32'd99, 32'd2, 1'b1, 1'b0, 1'b0);
        chk("acum_pronto", n_pronto, 1);
`ifdef CONTROLE_ACUMULA_EN
        chk("acum_lat", lat, 4);
        chk("acum_nwr", n_wr, 2);
        if (n_wr == 2) begin
            chk("acum_w0id", {30'd0, wr_id[0]}, 1);
            chk("acum_w0d",  wr_dat[0], 32'd2);
            chk("acum_w1id", {30'd0, wr_id[1]}, 2);
            chk("acum_w1d",  wr_dat[1], 32'd10);
        end
        chk("acum_f1", {30'd0, fonte1_acc}, 2);
        chk("acum_acc", bank[2], 32'd10);
`else
        chk("acum_lat", lat, 5);
        chk_writes3("acum", 32'd99, 32'd2, 32'd101);
        chk("acum_f1", {30'd0, fonte1_acc}, 0);
        chk("acum_acc", bank[2], 32'd101);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
